// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run controller, top_level and the bench.
package run_ctrl_pkg;

  localparam int unsigned DEFAULT_CYCLE_W = 16;
  localparam int unsigned DEFAULT_TIMEOUT = 4000;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LAUNCH,
    RUN,
    DONE
  } run_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // Clear takes priority so a new run always starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Sequences one program run of the single-cycle core: start/ack handshake,
// PC clear pulse, run enable, RUN-cycle count and watchdog timeout.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned CYCLE_W = DEFAULT_CYCLE_W,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               core_done,
  output logic               run,
  output logic               pc_clear,
  output logic               ack,
  output logic               timeout,
  output logic               busy,
  output logic [CYCLE_W-1:0] cycle_count
);

  localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(TIMEOUT - 1);

  run_state_t state;
  logic       count_clear;
  logic       count_enable;

  // The count is cleared on the edge that enters LAUNCH so it reads zero
  // during the LAUNCH cycle, and counts every edge that leaves a RUN cycle.
  assign count_clear  = (state == ARM) && !start;
  assign count_enable = (state == RUN);

  sat_counter #(
    .WIDTH (CYCLE_W)
  ) u_cycle_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (count_clear),
    .enable (count_enable),
    .count  (cycle_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      run      <= 1'b0;
      pc_clear <= 1'b0;
      ack      <= 1'b0;
      timeout  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          // Launch on the falling edge of start so the host may hold it.
          if (!start) begin
            state    <= LAUNCH;
            pc_clear <= 1'b1;
            timeout  <= 1'b0;
          end
        end
        LAUNCH: begin
          state    <= RUN;
          pc_clear <= 1'b0;
          run      <= 1'b1;
        end
        RUN: begin
          if (core_done) begin
            state   <= DONE;
            run     <= 1'b0;
            busy    <= 1'b0;
            ack     <= 1'b1;
            timeout <= 1'b0;
          end else if (cycle_count == LAST_CYCLE) begin
            state   <= DONE;
            run     <= 1'b0;
            busy    <= 1'b0;
            ack     <= 1'b1;
            timeout <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state <= ARM;
            ack   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          run      <= 1'b0;
          pc_clear <= 1'b0;
          ack      <= 1'b0;
          timeout  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
